// File: rtl/mcs4_bus_tracer.sv
// Passive MCS-4 bus tracer: follows the A1..X3 subcycles from sync and queues {seq, cmr, x2, opcode, pc} records.
// Define MCS4_TRACE_X2_EN to capture the X2 data nibble into record[23:20]; otherwise that field reads 0.
//
// state | meaning
// HUNT  | waiting for a sync pulse to find X3
// A1    | next pulse carries pc[3:0]; enable sampled here
// A2    | next pulse carries pc[7:4]
// A3    | next pulse carries pc[11:8]
// M1    | next pulse carries OPR
// M2    | next pulse carries OPA and cm_ram
// X1    | execute, nothing captured
// X2    | next pulse carries I/O data nibble
// X3    | sync expected; commit the record
module mcs4_bus_tracer #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken_2,
    input  logic               sync,
    input  logic [3:0]         cm_ram,
    input  logic [3:0]         dbus,
    input  logic               enable,
    output logic [31:0]        trace_data,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [LEVEL_W-1:0] level,
    output logic [15:0]        overflow_cnt,
    output logic               sync_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_HUNT, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   pc_q, pc_d;
    logic [7:0]    op_q, op_d;
    logic [3:0]    cmr_q, cmr_d;
    logic          en_q, en_d;
    logic          sync_err_q, sync_err_d;
    logic          commit;
    logic [3:0]    x2_nib;

`ifdef MCS4_TRACE_X2_EN
    logic [3:0]    x2_q, x2_d;
    assign x2_nib = x2_q;
`else
    assign x2_nib = 4'd0;
`endif

    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [LEVEL_W-1:0] cnt_q;
    logic [3:0]         seq_q;
    logic [15:0]        ovf_q;
    logic               full, push, pop, drop;
    logic [31:0]        rec;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        cmr_d      = cmr_q;
        en_d       = en_q;
        sync_err_d = sync_err_q;
        commit     = 1'b0;
`ifdef MCS4_TRACE_X2_EN
        x2_d       = x2_q;
`endif
        if (clken_2) begin
            case (state_q)
                S_HUNT: if (sync) state_d = S_A1;
                S_X3: begin
                    if (sync) begin
                        state_d = S_A1;
                        commit  = en_q;
                    end else begin
                        state_d    = S_HUNT;
                        sync_err_d = 1'b1;
                        en_d       = 1'b0;
                    end
                end
                default: begin
                    if (sync) begin
                        // early sync: this pulse was really X3, restart at A1
                        state_d    = S_A1;
                        sync_err_d = 1'b1;
                        en_d       = 1'b0;
                    end else begin
                        case (state_q)
                            S_A1: begin pc_d[3:0]  = dbus; en_d = enable; state_d = S_A2; end
                            S_A2: begin pc_d[7:4]  = dbus; state_d = S_A3; end
                            S_A3: begin pc_d[11:8] = dbus; state_d = S_M1; end
                            S_M1: begin op_d[7:4]  = dbus; state_d = S_M2; end
                            S_M2: begin op_d[3:0]  = dbus; cmr_d = cm_ram; state_d = S_X1; end
                            S_X1: state_d = S_X2;
                            S_X2: begin
`ifdef MCS4_TRACE_X2_EN
                                x2_d = dbus;
`endif
                                state_d = S_X3;
                            end
                            default: state_d = S_HUNT;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rec         = {seq_q, cmr_q, x2_nib, op_q, pc_q};
    assign trace_valid = (cnt_q != '0);
    assign full        = (cnt_q == LEVEL_W'(FIFO_DEPTH));
    assign pop         = trace_valid && trace_ready;
    assign push        = commit && (!full || pop);
    assign drop        = commit && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            pc_q       <= '0;
            op_q       <= '0;
            cmr_q      <= '0;
            en_q       <= 1'b0;
            sync_err_q <= 1'b0;
`ifdef MCS4_TRACE_X2_EN
            x2_q       <= '0;
`endif
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            seq_q      <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            cmr_q      <= cmr_d;
            en_q       <= en_d;
            sync_err_q <= sync_err_d;
`ifdef MCS4_TRACE_X2_EN
            x2_q       <= x2_d;
`endif
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (commit) seq_q <= seq_q + 1'b1;
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= rec;
    end

    assign trace_data   = trace_valid ? mem_q[rd_q] : 32'd0;
    assign level        = cnt_q;
    assign overflow_cnt = ovf_q;
    assign sync_err     = sync_err_q;
endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// Scoreboard bench for mcs4_bus_tracer: stimulus tasks queue expected records, a monitor checks every popped record.
module tb_mcs4_bus_tracer;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst, clken_2, sync, enable, trace_ready;
    logic [3:0]    cm_ram, dbus;
    logic [31:0]   trace_data;
    logic          trace_valid, sync_err;
    logic [LW-1:0] level;
    logic [15:0]   overflow_cnt;

    mcs4_bus_tracer #(.FIFO_DEPTH(DEPTH), .LEVEL_W(LW)) dut (
        .clk(clk), .rst(rst), .clken_2(clken_2), .sync(sync), .cm_ram(cm_ram),
        .dbus(dbus), .enable(enable), .trace_data(trace_data), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .level(level), .overflow_cnt(overflow_cnt), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    int          model_level = 0;
    logic [3:0]  model_seq = 4'd0;
    int          model_ovf = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && trace_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_record: got %h expected none", trace_data);
            end else begin
                chk("record", trace_data, exp_q.pop_front());
                model_level--;
            end
        end
    end

    task automatic sub(input logic s, input logic [3:0] d, input logic [3:0] cm, input logic en);
        @(posedge clk); #1;
        clken_2 = 1'b1; sync = s; dbus = d; cm_ram = cm; enable = en;
        @(posedge clk); #1;
        clken_2 = 1'b0; sync = 1'b0;
        @(posedge clk);
    endtask

    task automatic icycle(input logic [11:0] pc, input logic [7:0] op, input logic [3:0] cm,
                          input logic [3:0] x2, input logic en, input logic expect_commit,
                          input logic rdy_x3, input logic chk_lat);
        logic [3:0] x2e;
`ifdef MCS4_TRACE_X2_EN
        x2e = x2;
`else
        x2e = 4'd0;
`endif
        sub(1'b0, pc[3:0],  4'd0, en);
        sub(1'b0, pc[7:4],  4'd0, 1'b1);
        sub(1'b0, pc[11:8], 4'd0, 1'b1);
        sub(1'b0, op[7:4],  4'd0, 1'b1);
        sub(1'b0, op[3:0],  cm,   1'b1);
        sub(1'b0, 4'd0,     4'd0, 1'b1);
        sub(1'b0, x2,       4'd0, 1'b1);
        @(posedge clk); #1;
        clken_2 = 1'b1; sync = 1'b1; dbus = 4'd0; cm_ram = 4'd0; enable = 1'b1;
        if (rdy_x3) trace_ready = 1'b1;
        @(negedge clk); #1;
        if (chk_lat) chk("valid_before_commit", {31'd0, trace_valid}, 32'd0);
        if (en && expect_commit) begin
            if (model_level < DEPTH) begin
                exp_q.push_back({model_seq, cm, x2e, op, pc});
                model_level++;
            end else if (model_ovf < 65535) begin
                model_ovf++;
            end
            model_seq = model_seq + 4'd1;
        end
        @(posedge clk); #1;
        clken_2 = 1'b0; sync = 1'b0;
        if (rdy_x3) trace_ready = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            chk("valid_latency", {31'd0, trace_valid}, 32'd1);
        end
        @(posedge clk);
    endtask

    task automatic drain();
        trace_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("level_after_drain", {27'd0, level}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; clken_2 = 1'b0; sync = 1'b0; dbus = 4'd0; cm_ram = 4'd0;
        enable = 1'b0; trace_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, trace_valid}, 32'd0);
        chk("rst_data", trace_data, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);

        trace_ready = 1'b1;
        sub(1'b1, 4'd0, 4'd0, 1'b0);
        icycle(12'h234, 8'hD5, 4'h0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1);
        icycle(12'h9AB, 8'h21, 4'h2, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        icycle(12'h777, 8'h11, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        icycle(12'h456, 8'h7E, 4'h1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("no_sync_err_yet", {31'd0, sync_err}, 32'd0);

        sub(1'b0, 4'd1, 4'd0, 1'b1);
        sub(1'b0, 4'd2, 4'd0, 1'b1);
        sub(1'b0, 4'd3, 4'd0, 1'b1);
        sub(1'b1, 4'd4, 4'd0, 1'b1);
        @(negedge clk);
        chk("sync_err_set", {31'd0, sync_err}, 32'd1);
        icycle(12'hABC, 8'h40, 4'h8, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) sub(1'b0, 4'(i), 4'd0, 1'b1);
        icycle(12'h111, 8'h22, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        icycle(12'hFED, 8'hC3, 4'h4, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        chk("sync_err_sticky", {31'd0, sync_err}, 32'd1);

        trace_ready = 1'b0;
        icycle(12'h321, 8'h55, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("level_one", {27'd0, level}, 32'd1);
        sub(1'b0, 4'd1, 4'd0, 1'b1);
        sub(1'b0, 4'd2, 4'd0, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        model_level = 0; model_seq = 4'd0; model_ovf = 0;
        @(negedge clk);
        chk("rst2_level", {27'd0, level}, 32'd0);
        chk("rst2_valid", {31'd0, trace_valid}, 32'd0);
        chk("rst2_sync_err", {31'd0, sync_err}, 32'd0);

        sub(1'b1, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++)
            icycle(12'(12'h100 + i), 8'(i * 7), 4'(i), 4'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_level", {27'd0, level}, 32'd16);
        chk("full_ovf", {16'd0, overflow_cnt}, 32'd4);

        icycle(12'h5A5, 8'h99, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_pop_level", {27'd0, level}, 32'd16);
        chk("full_pop_ovf", {16'd0, overflow_cnt}, 32'd4);

        drain();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
